// File: rtl/alarm_controller.sv
// alarm_controller: alarm set-point storage, digit edit mode, and the
// ring / snooze / timeout sequencing that drives the buzzer.
module alarm_controller #(
    parameter int SNOOZE_MIN     = 5,   // snooze length in minutes (1..15)
    parameter int RING_TIMEOUT_S = 60   // ringing seconds before auto-stop (1..255)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] hrT,
    input  logic [3:0] hrU,
    input  logic [3:0] minT,
    input  logic [3:0] minU,
    input  logic [3:0] secT,
    input  logic [3:0] secU,
    input  logic       alarm_enable,
    input  logic       alarm_set,
    input  logic       digit_select,
    input  logic       increment,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [3:0] alm_hrT,
    output logic [3:0] alm_hrU,
    output logic [3:0] alm_minT,
    output logic [3:0] alm_minU,
    output logic [3:0] edit_sel,
    output logic       buzzer,
    output logic       snoozing
);

    typedef enum logic [1:0] {IDLE, EDIT, RINGING, SNOOZE} state_t;

    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
    localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_S - 1);

    state_t     state, stateNext;
    logic [3:0] almHrTNext, almHrUNext, almMinTNext, almMinUNext;
    logic [3:0] editSelNext;
    logic [7:0] ringCnt, ringCntNext;
    logic [9:0] snoozeCnt, snoozeCntNext;
    logic       buzzerNext, snoozingNext;
    logic       match, matchPrev, trigger;

    // Only the rising edge of a full HH:MM:00 match arms the alarm, so a
    // match that lasts the whole second, or a late enable, cannot re-fire.
    assign match   = (hrT == alm_hrT) && (hrU == alm_hrU) &&
                     (minT == alm_minT) && (minU == alm_minU) &&
                     (secT == 4'd0) && (secU == 4'd0);
    assign trigger = match && !matchPrev && alarm_enable;

    // Next-state and next-output logic; every register's next value defaults to hold.
    always_comb begin
        stateNext     = state;
        almHrTNext    = alm_hrT;
        almHrUNext    = alm_hrU;
        almMinTNext   = alm_minT;
        almMinUNext   = alm_minU;
        editSelNext   = edit_sel;
        ringCntNext   = ringCnt;
        snoozeCntNext = snoozeCnt;

        case (state)
            IDLE: begin
                if (alarm_set) begin
                    stateNext   = EDIT;
                    editSelNext = 4'b0001;
                end else if (trigger) begin
                    stateNext   = RINGING;
                    ringCntNext = 8'd0;
                end
            end

            EDIT: begin
                if (alarm_set) begin
                    stateNext   = IDLE;
                    editSelNext = 4'b0000;
                end else begin
                    // Increment acts on the current selection; any rotation
                    // requested in the same cycle lands afterwards.
                    if (increment) begin
                        case (edit_sel)
                            4'b0001: almMinUNext = (alm_minU >= 4'd9) ? 4'd0 : alm_minU + 4'd1;
                            4'b0010: almMinTNext = (alm_minT >= 4'd5) ? 4'd0 : alm_minT + 4'd1;
                            4'b0100: begin
                                if (alm_hrT == 4'd2)
                                    almHrUNext = (alm_hrU >= 4'd3) ? 4'd0 : alm_hrU + 4'd1;
                                else
                                    almHrUNext = (alm_hrU >= 4'd9) ? 4'd0 : alm_hrU + 4'd1;
                            end
                            4'b1000: begin
                                almHrTNext = (alm_hrT >= 4'd2) ? 4'd0 : alm_hrT + 4'd1;
                                // Stepping into the 20s would leave 24..29; clamp hrU.
                                if (alm_hrT == 4'd1 && alm_hrU > 4'd3)
                                    almHrUNext = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                    if (digit_select)
                        editSelNext = {edit_sel[2:0], edit_sel[3]};
                end
            end

            RINGING: begin
                if (dismiss || !alarm_enable) begin
                    stateNext = IDLE;
                end else if (snooze) begin
                    stateNext     = SNOOZE;
                    snoozeCntNext = SNOOZE_LOAD;
                end else if (tick) begin
                    if (ringCnt == RING_LAST)
                        stateNext = IDLE;
                    else
                        ringCntNext = ringCnt + 8'd1;
                end
            end

            SNOOZE: begin
                if (dismiss || !alarm_enable) begin
                    stateNext = IDLE;
                end else if (tick) begin
                    if (snoozeCnt == 10'd1) begin
                        stateNext   = RINGING;
                        ringCntNext = 8'd0;
                    end else begin
                        snoozeCntNext = snoozeCnt - 10'd1;
                    end
                end
            end

            default: stateNext = IDLE;
        endcase

        buzzerNext   = (stateNext == RINGING);
        snoozingNext = (stateNext == SNOOZE);
    end

    // State, set-point, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            alm_hrT   <= 4'd0;
            alm_hrU   <= 4'd6;
            alm_minT  <= 4'd0;
            alm_minU  <= 4'd0;
            edit_sel  <= 4'b0000;
            ringCnt   <= 8'd0;
            snoozeCnt <= 10'd0;
            buzzer    <= 1'b0;
            snoozing  <= 1'b0;
            matchPrev <= 1'b0;
        end else begin
            state     <= stateNext;
            alm_hrT   <= almHrTNext;
            alm_hrU   <= almHrUNext;
            alm_minT  <= almMinTNext;
            alm_minU  <= almMinUNext;
            edit_sel  <= editSelNext;
            ringCnt   <= ringCntNext;
            snoozeCnt <= snoozeCntNext;
            buzzer    <= buzzerNext;
            snoozing  <= snoozingNext;
            matchPrev <= match;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: edit-mode vector table, hand-written ring /
// snooze / reset sequences, and a random run against a seconds-based model.
module tb_alarm_controller;

    localparam int SN = 1;
    localparam int RT = 5;

    logic       clk = 1'b0;
    logic       rst, tick, alarm_enable, alarm_set, digit_select, increment, snooze, dismiss;
    logic [3:0] hrT, hrU, minT, minU, secT, secU;
    logic [3:0] alm_hrT, alm_hrU, alm_minT, alm_minU, edit_sel;
    logic       buzzer, snoozing;

    int checks = 0;
    int errors = 0;
    int curSec;

    alarm_controller #(.SNOOZE_MIN(SN), .RING_TIMEOUT_S(RT)) dut (
        .clk(clk), .reset(rst), .tick(tick),
        .hrT(hrT), .hrU(hrU), .minT(minT), .minU(minU), .secT(secT), .secU(secU),
        .alarm_enable(alarm_enable), .alarm_set(alarm_set), .digit_select(digit_select),
        .increment(increment), .snooze(snooze), .dismiss(dismiss),
        .alm_hrT(alm_hrT), .alm_hrU(alm_hrU), .alm_minT(alm_minT), .alm_minU(alm_minU),
        .edit_sel(edit_sel), .buzzer(buzzer), .snoozing(snoozing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setTime(input int s);
        hrT  = 4'(s / 36000);
        hrU  = 4'((s / 3600) % 10);
        minT = 4'((s % 3600) / 600);
        minU = 4'((s / 60) % 10);
        secT = 4'((s % 60) / 10);
        secU = 4'(s % 10);
    endtask

    task automatic clearPulses();
        tick = 0; alarm_set = 0; digit_select = 0; increment = 0; snooze = 0; dismiss = 0;
    endtask

    task automatic tickOnce();
        tick = 1;
        step();
        tick = 0;
        curSec = (curSec + 1) % 86400;
        setTime(curSec);
    endtask

    task automatic doReset();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Clock reads 05:59:59, then one tick reaches 06:00:00; buzzer must rise
    // exactly one cycle after the digits show it.
    task automatic ringUp(input string tag);
        curSec = 6 * 3600 - 1;
        setTime(curSec);
        step();
        step();
        tickOnce();
        check({tag, " pre-ring"}, buzzer, 0);
        step();
        check({tag, " ring rise"}, buzzer, 1);
    endtask

    // ---------------- edit-mode vector table ----------------
    typedef struct {
        logic       set, dsel, inc;
        logic [3:0] sel, hT, hU, mT, mU;
    } vec_t;
    vec_t vecs[$];

    function automatic void addVec(input logic s, input logic d, input logic i,
                                   input logic [3:0] sel, input int hT, input int hU,
                                   input int mT, input int mU);
        vec_t v;
        v.set = s; v.dsel = d; v.inc = i; v.sel = sel;
        v.hT = 4'(hT); v.hU = 4'(hU); v.mT = 4'(mT); v.mU = 4'(mU);
        vecs.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 edit, 2 ringing, 3 snoozing. Counters count ticks remaining.
    int mMode, mIdx, mRingLeft, mSnzLeft;
    int aHT, aHU, aMT, aMU;
    bit mPrev;

    function automatic int alarmSec();
        return (aHT * 10 + aHU) * 3600 + (aMT * 10 + aMU) * 60;
    endfunction

    function automatic int nowSec();
        return (int'(hrT) * 10 + int'(hrU)) * 3600 + (int'(minT) * 10 + int'(minU)) * 60 +
               int'(secT) * 10 + int'(secU);
    endfunction

    task automatic modelReset();
        mMode = 0; mIdx = 0; mRingLeft = 0; mSnzLeft = 0; mPrev = 0;
        aHT = 0; aHU = 6; aMT = 0; aMU = 0;
    endtask

    task automatic modelStep();
        bit m, trig;
        if (rst) begin
            modelReset();
            return;
        end
        m     = (nowSec() == alarmSec());
        trig  = m && !mPrev && alarm_enable;
        mPrev = m;
        case (mMode)
            0: if (alarm_set) begin mMode = 1; mIdx = 0; end
               else if (trig) begin mMode = 2; mRingLeft = RT; end
            1: if (alarm_set) mMode = 0;
               else begin
                   if (increment) begin
                       case (mIdx)
                           0: aMU = (aMU + 1) % 10;
                           1: aMT = (aMT + 1) % 6;
                           2: aHU = (aHU + 1) % ((aHT == 2) ? 4 : 10);
                           default: begin
                               aHT = (aHT + 1) % 3;
                               if (aHT == 2 && aHU > 3) aHU = 0;
                           end
                       endcase
                   end
                   if (digit_select) mIdx = (mIdx + 1) % 4;
               end
            2: if (dismiss || !alarm_enable) mMode = 0;
               else if (snooze) begin mMode = 3; mSnzLeft = SN * 60; end
               else if (tick) begin
                   mRingLeft--;
                   if (mRingLeft == 0) mMode = 0;
               end
            default: if (dismiss || !alarm_enable) mMode = 0;
               else if (tick) begin
                   mSnzLeft--;
                   if (mSnzLeft == 0) begin mMode = 2; mRingLeft = RT; end
               end
        endcase
    endtask

    function automatic logic [21:0] modelOut();
        logic [3:0] sel;
        sel = (mMode == 1) ? 4'(1 << mIdx) : 4'b0000;
        return {sel, 4'(aHT), 4'(aHU), 4'(aMT), 4'(aMU), mMode == 2, mMode == 3};
    endfunction

    initial begin
        rst = 1; alarm_enable = 1;
        clearPulses();
        curSec = 12 * 3600;
        setTime(curSec);

        // Test 1: reset state, ring on 06:00:00, timeout after RT ticks.
        doReset();
        check("reset alarm", {alm_hrT, alm_hrU, alm_minT, alm_minU}, 16'h0600);
        check("reset sel/buz/snz", {edit_sel, buzzer, snoozing}, 6'b0);
        ringUp("t1");
        for (int i = 1; i <= RT; i++) begin
            tickOnce();
            check($sformatf("t1 ring tick %0d", i), buzzer, (i < RT) ? 1 : 0);
        end

        // Test 2: snooze, re-ring after SN*60 ticks, dismiss+snooze together.
        ringUp("t2");
        snooze = 1; step(); snooze = 0;
        check("t2 snooze entry", {buzzer, snoozing}, 2'b01);
        for (int k = 1; k <= SN * 60; k++) begin
            tickOnce();
            if (k == SN * 60 - 1) check("t2 snooze penultimate", {buzzer, snoozing}, 2'b01);
            if (k == SN * 60)     check("t2 snooze end", {buzzer, snoozing}, 2'b10);
        end
        dismiss = 1; snooze = 1; step(); clearPulses();
        check("t2 dismiss", {buzzer, snoozing, edit_sel}, 6'b0);

        // Tests 3/4: edit-mode digit wraps and selection rotation.
        curSec = 12 * 3600 + 34 * 60 + 56;
        setTime(curSec);
        doReset();
        addVec(1, 0, 0, 4'b0001, 0, 6, 0, 0);
        addVec(0, 1, 0, 4'b0010, 0, 6, 0, 0);
        addVec(0, 1, 0, 4'b0100, 0, 6, 0, 0);
        addVec(0, 1, 0, 4'b1000, 0, 6, 0, 0);
        addVec(0, 0, 1, 4'b1000, 1, 6, 0, 0);
        addVec(0, 0, 1, 4'b1000, 2, 0, 0, 0);
        addVec(0, 1, 0, 4'b0001, 2, 0, 0, 0);
        for (int k = 1; k <= 10; k++) addVec(0, 0, 1, 4'b0001, 2, 0, 0, k % 10);
        addVec(0, 1, 0, 4'b0010, 2, 0, 0, 0);
        addVec(0, 1, 1, 4'b0100, 2, 0, 1, 0);
        addVec(0, 0, 1, 4'b0100, 2, 1, 1, 0);
        addVec(0, 0, 1, 4'b0100, 2, 2, 1, 0);
        addVec(0, 0, 1, 4'b0100, 2, 3, 1, 0);
        addVec(0, 0, 1, 4'b0100, 2, 0, 1, 0);
        addVec(0, 1, 0, 4'b1000, 2, 0, 1, 0);
        addVec(0, 0, 1, 4'b1000, 0, 0, 1, 0);
        addVec(0, 0, 1, 4'b1000, 1, 0, 1, 0);
        addVec(0, 1, 0, 4'b0001, 1, 0, 1, 0);
        addVec(0, 1, 0, 4'b0010, 1, 0, 1, 0);
        for (int k = 1; k <= 5; k++) addVec(0, 0, 1, 4'b0010, 1, 0, (1 + k) % 6, 0);
        addVec(1, 0, 0, 4'b0000, 1, 0, 0, 0);
        foreach (vecs[i]) begin
            alarm_set = vecs[i].set; digit_select = vecs[i].dsel; increment = vecs[i].inc;
            step();
            clearPulses();
            check($sformatf("edit[%0d]", i),
                  {edit_sel, alm_hrT, alm_hrU, alm_minT, alm_minU},
                  {vecs[i].sel, vecs[i].hT, vecs[i].hU, vecs[i].mT, vecs[i].mU});
        end

        // Test 5: disabled at the match, late enable must not fire.
        doReset();
        alarm_enable = 0;
        curSec = 6 * 3600 - 1;
        setTime(curSec);
        step(); step();
        tickOnce();
        step();
        check("t5 disabled match", buzzer, 0);
        alarm_enable = 1;
        step();
        check("t5 late enable a", buzzer, 0);
        step();
        check("t5 late enable b", buzzer, 0);

        // Test 6: reset on the 3rd ringing tick.
        doReset();
        ringUp("t6");
        tickOnce(); tickOnce();
        check("t6 still ringing", buzzer, 1);
        tick = 1; rst = 1; step(); tick = 0; rst = 0;
        check("t6 reset mid-ring", {buzzer, snoozing, edit_sel, alm_hrT, alm_hrU, alm_minT, alm_minU},
              {2'b00, 4'b0000, 16'h0600});
        step();
        check("t6 idle after reset", buzzer, 0);

        // Random run against the model.
        rst = 1; alarm_enable = 1;
        clearPulses();
        curSec = 6 * 3600 - 10;
        setTime(curSec);
        @(posedge clk); modelStep(); #1;
        rst = 0;
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(999) == 0);
            tick         = ($urandom_range(1) == 0);
            alarm_set    = ($urandom_range(63) == 0);
            digit_select = ($urandom_range(7) == 0);
            increment    = ($urandom_range(7) == 0);
            snooze       = ($urandom_range(39) == 0);
            dismiss      = ($urandom_range(79) == 0);
            if ($urandom_range(149) == 0) alarm_enable = ~alarm_enable;
            if (mMode == 0 && $urandom_range(99) == 0)
                curSec = (alarmSec() + 86400 - 4) % 86400;
            setTime(curSec);
            @(posedge clk);
            modelStep();
            if (tick) curSec = (curSec + 1) % 86400;
            #1;
            check($sformatf("random cycle %0d", c),
                  {edit_sel, alm_hrT, alm_hrU, alm_minT, alm_minU, buzzer, snoozing}, modelOut());
        end
        clearPulses();
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequences the alarm function of the alarm clock. It holds the alarm set-point (HH:MM) and runs its edit mode from the debounced pushbutton pulses. It compares the set-point against the running time digits and drives the buzzer through ringing, snooze and timeout. It sits beside the time-keeping registers, consumes their digit outputs and the one-per-second `inc` tick, and feeds its alarm digits to the display path.

## Interface
Parameters:
- SNOOZE_MIN, 5, snooze length in minutes (1..15)
- RING_TIMEOUT_S, 60, seconds of ringing before auto-stop (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse once per second (time-keeping `inc`)
- hrT, hrU, minT, minU, secT, secU  in  4 each  current BCD time digits
- alarm_enable  in  1  level; alarm armed when 1
- alarm_set  in  1  debounced one-cycle pulse; enter/leave edit
- digit_select  in  1  debounced one-cycle pulse; rotate edit digit
- increment  in  1  debounced one-cycle pulse; bump selected digit
- snooze  in  1  debounced one-cycle pulse
- dismiss  in  1  debounced one-cycle pulse
- alm_hrT, alm_hrU, alm_minT, alm_minU  out  4 each  alarm set-point, BCD
- edit_sel  out  4  one-hot edit digit {hrT,hrU,minT,minU}; 0 outside EDIT
- buzzer  out  1  alarm sound request
- snoozing  out  1  high in SNOOZE

## Operation
- States: IDLE, EDIT, RINGING, SNOOZE. All outputs are registered.
- Reset values: state IDLE, alarm 06:00 (alm_hrT=0, alm_hrU=6, alm_minT=0, alm_minU=0), edit_sel=0, buzzer=0, snoozing=0, counters 0, match_prev=0.
- match = (time digits == alarm HH:MM) && secT==0 && secU==0. match_prev registers match every cycle. trigger = match && !match_prev && alarm_enable.
- IDLE:
  - alarm_set -> EDIT, edit_sel=0001 (minU).
  - Otherwise trigger -> RINGING, ring_cnt=0.
- EDIT:
  - Triggers are ignored.
  - digit_select rotates edit_sel left: 0001→0010→0100→1000→0001.
  - increment bumps the selected digit with wrap:
    - minU: 9→0
    - minT: 5→0
    - hrU: 9→0, or 3→0 when alm_hrT==2
    - hrT: 2→0. When hrT becomes 2 and alm_hrU>3, hrU is forced to 0 in the same cycle.
  - Carries never propagate between digits.
  - alarm_set -> IDLE, edit_sel=0.
  - digit_select and increment in the same cycle: increment applies to the old selection, then the selection rotates.
- RINGING: buzzer=1. Priority, highest first:
  - reset
  - dismiss or !alarm_enable -> IDLE
  - snooze -> SNOOZE, snooze_cnt=SNOOZE_MIN*60
  - tick with ring_cnt==RING_TIMEOUT_S-1 -> IDLE
  - tick -> ring_cnt+1
  - alarm_set is ignored.
- SNOOZE: snoozing=1, buzzer=0. Priority, highest first:
  - dismiss or !alarm_enable -> IDLE
  - tick with snooze_cnt==1 -> RINGING, ring_cnt=0
  - tick -> snooze_cnt-1
  - alarm_set and snooze are ignored.
- Widths:
  - ring_cnt is 8 bits.
  - snooze_cnt is 10 bits (max 900).
  - Digit arithmetic is 4-bit BCD with explicit wrap. No binary overflow is permitted.

## Timing
- trigger is evaluated combinationally from the current digits. buzzer rises on the clock edge after the first cycle in which match is true, i.e. one cycle after the time registers reach HH:MM:00.
- Ringing lasts exactly RING_TIMEOUT_S ticks. buzzer falls on the edge of the RING_TIMEOUT_S-th tick after entry.
- A snooze lasts exactly SNOOZE_MIN*60 ticks. buzzer re-rises on the edge of the last tick.
- Pulse inputs act on the edge where they are sampled high. Results are visible the next cycle.
- A match persisting across the whole second (or re-arming alarm_enable mid-second) does not re-trigger. Only the rising edge of match triggers.
- Reset asserted in any state returns all registers to reset values on the same edge, including mid-ring and mid-edit.
- An alarm edit that makes the set-point equal the current time with seconds 00 triggers only after leaving EDIT and only if match then rises. It does not trigger retroactively.

## Test plan
Use SNOOZE_MIN=1 and RING_TIMEOUT_S=5.
1. Reset, then drive time 05:59:59 → 06:00:00 with a tick, alarm_enable=1 -> buzzer=1 exactly one cycle after the digits read 060000; 5 further ticks -> buzzer=0, state IDLE.
2. While ringing, pulse snooze -> buzzer=0 and snoozing=1 next cycle; after 60 ticks buzzer=1; pulse dismiss and snooze in the same cycle -> IDLE, buzzer=0, snoozing=0.
3. Edit: alarm_set, then digit_select×3 (edit_sel=1000), then increment×2 -> alm_hrT=2 and alm_hrU forced 6→0; digit_select -> edit_sel=0001; increment×10 on minU -> wraps back to 0.
4. Hour wrap with alm_hrT=2, alm_hrU=3: increment on hrU -> 0; increment on hrT -> 0; alarm_set -> IDLE with edit_sel=0.
5. alarm_enable=0 at the 06:00:00 match -> no buzzer; raise alarm_enable while the digits still read 060000 -> no buzzer (no match edge).
6. Assert reset on the 3rd tick of RINGING -> next cycle buzzer=0, state IDLE, alarm digits 06:00.
